// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU (M stage) vs external bridge.
// Optional macro DM_ARB_BE_CHECK_EN suppresses illegal byte-enable writes and flags them on be_err.
module dm_port_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteen,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic [31:0] ext_addr,
    input  logic [3:0]  ext_byteen,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_byteen,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
`ifdef DM_ARB_BE_CHECK_EN
    ,
    output logic        be_err
`endif
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        CPU_OWN = 1'b0,
        EXT_OWN = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [WW-1:0]   wait_cnt_r, wait_nxt_s;
    logic [BW-1:0]   beat_cnt_r, beat_nxt_s;
    logic            cpu_svc_s;
    logic            ext_beat_s;
    logic [31:0]     sel_addr_s;
    logic [3:0]      sel_be_s;
    logic [31:0]     sel_wdata_s;
    logic            be_ok_s;

`ifdef DM_ARB_BE_CHECK_EN
    logic            be_err_r;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                            be_legal = 1'b0;
        endcase
    endfunction
`endif

    // Ownership decision, starvation and burst accounting.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        beat_nxt_s  = beat_cnt_r;
        cpu_svc_s   = 1'b0;
        ext_beat_s  = 1'b0;
        case (state_r)
            CPU_OWN: begin
                cpu_svc_s  = cpu_req;
                beat_nxt_s = '0;
                if (!ext_req) begin
                    wait_nxt_s = '0;
                end else if (!cpu_req || (wait_cnt_r == WAIT_LAST)) begin
                    state_nxt_s = EXT_OWN;
                    wait_nxt_s  = '0;
                end else if (wait_cnt_r < WAIT_MAX) begin
                    wait_nxt_s = wait_cnt_r + WW'(1);
                end else begin
                    wait_nxt_s = wait_cnt_r;
                end
            end
            EXT_OWN: begin
                // An absent external request hands the slot straight back to the CPU.
                if (ext_req) begin
                    ext_beat_s = 1'b1;
                    if (beat_cnt_r == BURST_LAST) begin
                        state_nxt_s = CPU_OWN;
                        beat_nxt_s  = '0;
                        wait_nxt_s  = '0;
                    end else begin
                        beat_nxt_s = beat_cnt_r + BW'(1);
                    end
                end else begin
                    cpu_svc_s   = cpu_req;
                    state_nxt_s = CPU_OWN;
                    beat_nxt_s  = '0;
                    wait_nxt_s  = '0;
                end
            end
            default: begin
                state_nxt_s = CPU_OWN;
                wait_nxt_s  = '0;
                beat_nxt_s  = '0;
            end
        endcase
    end

    // Memory port mux: serviced requester drives dm_*, otherwise all zero.
    always_comb begin
        sel_addr_s  = 32'h0000_0000;
        sel_be_s    = 4'b0000;
        sel_wdata_s = 32'h0000_0000;
        if (ext_beat_s) begin
            sel_addr_s  = ext_addr;
            sel_be_s    = ext_byteen;
            sel_wdata_s = ext_wdata;
        end else if (cpu_svc_s) begin
            sel_addr_s  = cpu_addr;
            sel_be_s    = cpu_byteen;
            sel_wdata_s = cpu_wdata;
        end else begin
            sel_addr_s  = 32'h0000_0000;
        end
`ifdef DM_ARB_BE_CHECK_EN
        be_ok_s = be_legal(sel_be_s);
`else
        be_ok_s = 1'b1;
`endif
    end

    assign dm_addr   = sel_addr_s;
    assign dm_wdata  = sel_wdata_s;
    assign dm_byteen = be_ok_s ? sel_be_s : 4'b0000;
    assign cpu_stall = cpu_req & ~cpu_svc_s;
    assign cpu_rdata = dm_rdata;
    assign ext_gnt   = ext_beat_s;

    // State, counters and registered external read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= CPU_OWN;
            wait_cnt_r <= '0;
            beat_cnt_r <= '0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            beat_cnt_r <= beat_nxt_s;
            if (ext_beat_s && (ext_byteen == 4'b0000)) begin
                ext_rvalid <= 1'b1;
                ext_rdata  <= dm_rdata;
            end else begin
                ext_rvalid <= 1'b0;
            end
        end
    end

`ifdef DM_ARB_BE_CHECK_EN
    // One-cycle error pulse after a serviced access with an illegal byte-enable pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            be_err_r <= 1'b0;
        end else begin
            be_err_r <= ~be_ok_s;
        end
    end

    assign be_err = be_err_r;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized traffic vs. an ownership model.
module tb_dm_port_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic [3:0]  ext_byteen;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
`ifdef DM_ARB_BE_CHECK_EN
    logic        be_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_byteen(ext_byteen), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef DM_ARB_BE_CHECK_EN
        , .be_err(be_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_be(input logic [3:0] be);
`ifdef DM_ARB_BE_CHECK_EN
        return (be == 4'b0000) || (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
               (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: who owns the port, how many CPU cycles the pending external
    // request has sat through, and how many beats the current burst has used.
    bit          m_ext_owns = 1'b0;
    int          m_waited   = 0;
    int          m_beats    = 0;
    bit          m_rvalid   = 1'b0;
    logic [31:0] m_rdata    = 32'h0;
    bit          m_beerr    = 1'b0;

    initial begin
        bit          beat, csvc, ok;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        forever begin
            @(negedge clk);
            beat = m_ext_owns && ext_req;
            csvc = cpu_req && !beat;
            if (beat)      begin e_addr = ext_addr; e_be = ext_byteen; e_wdata = ext_wdata; end
            else if (csvc) begin e_addr = cpu_addr; e_be = cpu_byteen; e_wdata = cpu_wdata; end
            else           begin e_addr = 32'h0;    e_be = 4'b0000;    e_wdata = 32'h0;     end
            ok = legal_be(e_be);
            if (chk_en) begin
                check("m_dm_addr",   dm_addr,  e_addr);
                check("m_dm_byteen", {28'h0, dm_byteen}, {28'h0, ok ? e_be : 4'b0000});
                check("m_dm_wdata",  dm_wdata, e_wdata);
                check("m_cpu_stall", {31'h0, cpu_stall}, {31'h0, cpu_req && !csvc});
                check("m_ext_gnt",   {31'h0, ext_gnt},   {31'h0, beat});
                check("m_cpu_rdata", cpu_rdata, dm_rdata);
                check("m_ext_rvalid", {31'h0, ext_rvalid}, {31'h0, m_rvalid});
                check("m_ext_rdata",  ext_rdata, m_rdata);
`ifdef DM_ARB_BE_CHECK_EN
                check("m_be_err", {31'h0, be_err}, {31'h0, m_beerr});
`endif
            end
            if (reset) begin
                m_ext_owns = 1'b0; m_waited = 0; m_beats = 0;
                m_rvalid = 1'b0; m_rdata = 32'h0; m_beerr = 1'b0;
            end else begin
                m_beerr  = !ok;
                m_rvalid = beat && (ext_byteen == 4'b0000);
                if (m_rvalid) m_rdata = dm_rdata;
                if (m_ext_owns) begin
                    if (!ext_req) begin
                        m_ext_owns = 1'b0; m_waited = 0; m_beats = 0;
                    end else begin
                        m_beats++;
                        if (m_beats == BURST_MAX) begin
                            m_ext_owns = 1'b0; m_waited = 0; m_beats = 0;
                        end
                    end
                end else if (!ext_req) begin
                    m_waited = 0;
                end else if (!cpu_req) begin
                    m_ext_owns = 1'b1;
                end else begin
                    m_waited++;
                    if (m_waited == MAX_WAIT) begin
                        m_ext_owns = 1'b1; m_waited = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; cpu_byteen = 4'b0000; cpu_wdata = 32'h0;
        ext_req = 1'b0; ext_addr = 32'h0; ext_byteen = 4'b0000; ext_wdata = 32'h0; dm_rdata = 32'h0;
        step(); step();
        reset = 1'b0; chk_en = 1'b1;

        // Reset state
        probe();
        check("rst_rvalid", {31'h0, ext_rvalid}, 32'h0);
        check("rst_rdata",  ext_rdata, 32'h0);
        check("rst_dm_be",  {28'h0, dm_byteen}, 32'h0);
        check("rst_dm_addr", dm_addr, 32'h0);
        step();

        // CPU only
        cpu_req = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'b1100; cpu_wdata = 32'hABCD_0000;
        for (int i = 0; i < 3; i++) begin
            probe();
            check("cpu_dm_be",   {28'h0, dm_byteen}, 32'h0000_000C);
            check("cpu_dm_addr", dm_addr, 32'h10);
            check("cpu_stall0",  {31'h0, cpu_stall}, 32'h0);
            check("cpu_gnt0",    {31'h0, ext_gnt},   32'h0);
            step();
        end

        // External read with CPU idle
        cpu_req = 1'b0; ext_req = 1'b1; ext_addr = 32'h20; ext_byteen = 4'b0000; dm_rdata = 32'h1234_5678;
        probe(); check("xr_gnt_c0", {31'h0, ext_gnt}, 32'h0); step();
        probe(); check("xr_gnt_c1", {31'h0, ext_gnt}, 32'h1); check("xr_addr_c1", dm_addr, 32'h20); step();
        ext_req = 1'b0; dm_rdata = 32'h0;
        probe();
        check("xr_rvalid_c2", {31'h0, ext_rvalid}, 32'h1);
        check("xr_rdata_c2",  ext_rdata, 32'h1234_5678);
        check("xr_gnt_c2",    {31'h0, ext_gnt}, 32'h0);
        step();
        probe(); check("xr_rvalid_c3", {31'h0, ext_rvalid}, 32'h0); step();

        // Starvation bound: 4 CPU cycles then 4 external write beats, repeating
        cpu_req = 1'b1; cpu_byteen = 4'b1111; cpu_addr = 32'h40;
        ext_req = 1'b1; ext_byteen = 4'b1111; ext_addr = 32'h80; ext_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 30; i++) begin
            probe();
            check("starve_gnt",   {31'h0, ext_gnt},   {31'h0, (i % 8) >= 4});
            check("starve_stall", {31'h0, cpu_stall}, {31'h0, (i % 8) >= 4});
            step();
        end

        // Early burst end after two beats: CPU serviced in the same cycle
        ext_req = 1'b0;
        probe();
        check("early_stall",   {31'h0, cpu_stall}, 32'h0);
        check("early_dm_addr", dm_addr, 32'h40);
        check("early_gnt",     {31'h0, ext_gnt}, 32'h0);
        step();

        // Reset during the second beat of a read burst
        ext_req = 1'b1; ext_byteen = 4'b0000; dm_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        probe(); check("rb_beat2_gnt", {31'h0, ext_gnt}, 32'h1);
        step();
        reset = 1'b0;
        probe();
        check("rb_gnt",    {31'h0, ext_gnt},    32'h0);
        check("rb_rvalid", {31'h0, ext_rvalid}, 32'h0);
        check("rb_dm_be",  {28'h0, dm_byteen},  32'h0000_000F);
        step();
        for (int i = 1; i < 5; i++) begin
            probe();
            check("rb_rearb_gnt", {31'h0, ext_gnt}, {31'h0, i == 4});
            step();
        end

`ifdef DM_ARB_BE_CHECK_EN
        // Illegal byte enables on a CPU write
        reset = 1'b1; step(); reset = 1'b0;
        ext_req = 1'b0; cpu_req = 1'b1; cpu_byteen = 4'b0110;
        probe(); check("be_dm_be", {28'h0, dm_byteen}, 32'h0); step();
        cpu_byteen = 4'b1111;
        probe(); check("be_err_1", {31'h0, be_err}, 32'h1); step();
        probe(); check("be_err_0", {31'h0, be_err}, 32'h0); step();
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            cpu_req    = ($urandom_range(0, 3) != 0);
            cpu_addr   = $urandom;
            cpu_byteen = 4'($urandom_range(0, 15));
            cpu_wdata  = $urandom;
            if (!ext_req || ($urandom_range(0, 3) == 0)) ext_req = ($urandom_range(0, 9) < 6);
            ext_addr   = $urandom;
            ext_byteen = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            ext_wdata  = $urandom;
            dm_rdata   = $urandom;
            step();
        end
        reset = 1'b0; cpu_req = 1'b0; ext_req = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
